// File: rtl/connect4_pkg.sv
// Shared Connect Four constants, win encodings, sequencer states and cursor helpers.
package connect4_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int COL_W = 3;
  localparam int ROW_W = 3;
  localparam int CELLS = COLS * ROWS;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_RED    = 2'b01;
  localparam logic [1:0] WIN_YELLOW = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    SELECT = 3'd0,
    DROP   = 3'd1,
    WRITE  = 3'd2,
    CHECK  = 3'd3,
    OVER   = 3'd4
  } state_t;

  function automatic col_t wrap_right(input col_t c);
    return (c == col_t'(COLS - 1)) ? '0 : col_t'(c + 1'b1);
  endfunction

  function automatic col_t wrap_left(input col_t c);
    return (c == '0) ? col_t'(COLS - 1) : col_t'(c - 1'b1);
  endfunction

endpackage

// File: rtl/column_height_tracker.sv
// Per-column fill heights of the board: increment on a write, clear on restart,
// and a full flag per column.
module column_height_tracker
  import connect4_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  input  col_t                  inc_col,
  output row_t [COLS-1:0]       heights,
  output logic [COLS-1:0]       full
);

  // NOTE: the heights are a handful of flops, not a RAM, so they take the reset
  // like any other state; a restart clears them through the same path.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      heights <= '0;
    end else if (inc) begin
      for (int c = 0; c < COLS; c++) begin
        if (inc_col == col_t'(c) && heights[c] != row_t'(ROWS)) begin
          heights[c] <= heights[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      full[c] = (heights[c] == row_t'(ROWS));
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Connect Four turn controller: cursor, disc drop animation, board write, win check.
// Define MOVE_SEQ_CPU_EN to let the CPU port play the yellow moves.
module move_sequencer
  import connect4_pkg::*;
#(
  parameter int START_COL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       right,
  input  logic       left,
  input  logic       enter,
  input  logic       tick,
  input  logic       check_done,
  input  logic [1:0] win_in,
  input  logic       cpu_req,
  input  logic [2:0] cpu_col,
  output logic       cpu_ack,
  output logic [2:0] cursor,
  output logic       player,
  output logic       drop_active,
  output logic [2:0] drop_row,
  output logic       wr_en,
  output logic [2:0] wr_col,
  output logic [2:0] wr_row,
  output logic       check_start,
  output logic       clear_board,
  output logic [6:0] col_full,
  output logic [1:0] win
);

  state_t          state;
  col_t            col;
  logic [5:0]      move_count;
  row_t [COLS-1:0] heights;
  logic [COLS-1:0] full;
  row_t            col_height;
  logic            cursor_full;
  logic            restart;
  logic            cpu_turn;
  logic            cpu_valid;

  assign restart = (state == OVER) && enter;

  column_height_tracker u_heights (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .inc     (wr_en),
    .inc_col (col),
    .heights (heights),
    .full    (full)
  );

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    col_height  = '0;
    cursor_full = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (col == col_t'(c))    col_height  = heights[c];
      if (cursor == col_t'(c)) cursor_full = full[c];
    end
  end

`ifdef MOVE_SEQ_CPU_EN
  logic cpu_col_full;

  always_comb begin
    cpu_col_full = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (cpu_col == col_t'(c)) cpu_col_full = full[c];
    end
  end

  // Yellow's turn belongs to the CPU port; buttons are locked out meanwhile.
  assign cpu_turn  = (state == SELECT) && player;
  assign cpu_valid = (cpu_col < col_t'(COLS)) && !cpu_col_full;
`else
  logic unused_cpu_col;

  assign cpu_turn       = 1'b0;
  assign cpu_valid      = 1'b0;
  assign unused_cpu_col = ^cpu_col;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state       <= SELECT;
      cursor      <= col_t'(START_COL);
      player      <= 1'b0;
      move_count  <= '0;
      win         <= WIN_NONE;
      col         <= '0;
      drop_row    <= '0;
      check_start <= 1'b0;
      cpu_ack     <= 1'b0;
      clear_board <= restart && !reset;
    end else begin
      check_start <= 1'b0;
      clear_board <= 1'b0;
      cpu_ack     <= cpu_turn && cpu_req;

      case (state)
        SELECT: begin
          if (cpu_turn) begin
            if (cpu_req && cpu_valid) begin
              cursor   <= cpu_col;
              col      <= cpu_col;
              drop_row <= row_t'(ROWS - 1);
              state    <= DROP;
            end
          end else if (enter) begin
            // Enter wins over a same-cycle right/left, even when it is refused.
            if (!cursor_full) begin
              col      <= cursor;
              drop_row <= row_t'(ROWS - 1);
              state    <= DROP;
            end
          end else if (right && !left) begin
            cursor <= wrap_right(cursor);
          end else if (left && !right) begin
            cursor <= wrap_left(cursor);
          end
        end

        DROP: begin
          if (drop_row == col_height) begin
            state <= WRITE;
          end else if (tick) begin
            drop_row <= drop_row - 1'b1;
          end
        end

        WRITE: begin
          move_count  <= move_count + 1'b1;
          check_start <= 1'b1;
          state       <= CHECK;
        end

        CHECK: begin
          if (check_done) begin
            if (win_in != WIN_NONE) begin
              win   <= win_in;
              state <= OVER;
            end else if (move_count == 6'(CELLS)) begin
              win   <= WIN_DRAW;
              state <= OVER;
            end else begin
              player <= ~player;
              state  <= SELECT;
            end
          end
        end

        OVER: begin
          state <= OVER;
        end

        default: begin
          state <= SELECT;
        end
      endcase
    end
  end

  assign drop_active = (state == DROP);
  assign wr_en       = (state == WRITE);
  assign wr_col      = wr_en ? col : '0;
  assign wr_row      = wr_en ? col_height : '0;
  assign col_full    = full;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: randomized games against a move-level
// model of the board (heights, cursor, player, move count, result).
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       reset, right, left, enter, tick, check_done, cpu_req;
  logic [1:0] win_in;
  logic [2:0] cpu_col;
  logic       cpu_ack;
  logic [2:0] cursor;
  logic       player, drop_active;
  logic [2:0] drop_row;
  logic       wr_en;
  logic [2:0] wr_col, wr_row;
  logic       check_start, clear_board;
  logic [6:0] col_full;
  logic [1:0] win;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model of the game, tracked per move.
  int m_cursor, m_player, m_moves, m_win;
  int m_h[7];

  always #5 clk = ~clk;

  move_sequencer #(.START_COL(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .right       (right),
    .left        (left),
    .enter       (enter),
    .tick        (tick),
    .check_done  (check_done),
    .win_in      (win_in),
    .cpu_req     (cpu_req),
    .cpu_col     (cpu_col),
    .cpu_ack     (cpu_ack),
    .cursor      (cursor),
    .player      (player),
    .drop_active (drop_active),
    .drop_row    (drop_row),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .check_start (check_start),
    .clear_board (clear_board),
    .col_full    (col_full),
    .win         (win)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    right = 0; left = 0; enter = 0; tick = 0; check_done = 0;
    win_in = 2'b00; cpu_req = 0; cpu_col = 3'd0;
  endtask

  task automatic model_reset();
    m_cursor = 3; m_player = 0; m_moves = 0; m_win = 0;
    foreach (m_h[i]) m_h[i] = 0;
  endtask

  function automatic int model_full_vec();
    int v = 0;
    for (int i = 0; i < 7; i++) if (m_h[i] == 6) v |= (1 << i);
    return v;
  endfunction

  function automatic bit model_cpu_turn();
`ifdef MOVE_SEQ_CPU_EN
    return (m_player == 1) && (m_win == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".cursor"},   cursor,      m_cursor);
    check({tag, ".player"},   player,      m_player);
    check({tag, ".win"},      win,         m_win);
    check({tag, ".col_full"}, col_full,    model_full_vec());
    check({tag, ".drop_act"}, drop_active, 0);
    check({tag, ".wr_en"},    wr_en,       0);
  endtask

  task automatic pulse_move(input bit r, input bit l);
    right = r; left = l;
    step();
    right = 0; left = 0;
    if (m_win == 0 && !model_cpu_turn()) begin
      if (r && !l) m_cursor = (m_cursor + 1) % 7;
      if (l && !r) m_cursor = (m_cursor + 6) % 7;
    end
    check("move.cursor", cursor, m_cursor);
  endtask

  task automatic navigate(input int c);
    for (int it = 0; it < 20 && m_cursor != c; it++) begin
      int dr;
      dr = (c - m_cursor + 7) % 7;
      if (it < 3 && $urandom_range(2) == 0) pulse_move(1, 1);
      else if (dr <= 3)                     pulse_move(1, 0);
      else                                  pulse_move(0, 1);
    end
  endtask

  // Requests a move in column c; reports whether the disc started falling.
  task automatic start_drop(input int c, output bit started);
    started = 0;
`ifdef MOVE_SEQ_CPU_EN
    if (model_cpu_turn()) begin
      if (c < 7) started = (m_h[c] < 6);
      cpu_req = 1; cpu_col = 3'(c);
      step();
      cpu_req = 0;
      if (started) m_cursor = c;
      check("cpu.ack",    cpu_ack,     1);
      check("cpu.cursor", cursor,      m_cursor);
      check("cpu.drop",   drop_active, started);
    end else
`endif
    begin
      navigate(c);
      started = (m_h[c] < 6);
      enter = 1;
      right = ($urandom_range(3) == 0);
      step();
      enter = 0; right = 0;
      check("enter.cursor", cursor,      m_cursor);
      check("enter.drop",   drop_active, started);
    end
    if (started) check("enter.row", drop_row, 5);
  endtask

  task automatic animate(input int c, input int code);
    int row, land;
    row  = 5;
    land = m_h[c];
    while (row > land) begin
      repeat ($urandom_range(2)) begin
        right = $urandom_range(1); left = $urandom_range(1);
        enter = $urandom_range(1); check_done = $urandom_range(1);
        step();
        clear_inputs();
        check("drop.hold_row", drop_row,    row);
        check("drop.active",   drop_active, 1);
        check("drop.cursor",   cursor,      m_cursor);
      end
      tick = 1;
      step();
      tick = 0;
      row--;
      check("drop.row", drop_row, row);
    end
    tick = $urandom_range(1);
    step();
    tick = 0;
    check("write.en",     wr_en,       1);
    check("write.col",    wr_col,      c);
    check("write.row",    wr_row,      land);
    check("write.active", drop_active, 0);
    check("write.cstart", check_start, 0);
    m_h[c]++;
    m_moves++;
    step();
    check("check.start",  check_start, 1);
    check("check.wr_en",  wr_en,       0);
    check("check.full",   col_full,    model_full_vec());
    repeat ($urandom_range(3)) begin
      right = $urandom_range(1); left = $urandom_range(1); enter = $urandom_range(1);
      step();
      clear_inputs();
      check("check.start_once", check_start, 0);
      check("check.cursor",     cursor,      m_cursor);
    end
    check_done = 1; win_in = 2'(code);
    step();
    clear_inputs();
    if (code != 0)         m_win = code;
    else if (m_moves == 42) m_win = 3;
    else                   m_player ^= 1;
    check_status("done");
  endtask

  task automatic do_move(input int c, input int code);
    bit started;
    start_drop(c, started);
    if (started) animate(c, code);
  endtask

  task automatic restart();
    enter = 1;
    step();
    enter = 0;
    model_reset();
    check("restart.clear", clear_board, 1);
    check_status("restart");
    step();
    check("restart.clear_once", clear_board, 0);
  endtask

  initial begin
    bit started;
    clear_inputs();
    model_reset();
    reset = 1;
    repeat (3) step();
    check_status("reset");
    check("reset.drop_row", drop_row,    0);
    check("reset.wr_col",   wr_col,      0);
    check("reset.wr_row",   wr_row,      0);
    check("reset.cstart",   check_start, 0);
    check("reset.clear",    clear_board, 0);
    check("reset.cpu_ack",  cpu_ack,     0);
    reset = 0;

    repeat (8) pulse_move(1, 0);
    check("wrap.cursor", cursor, 4);
    pulse_move(1, 1);
    check("both.cursor", cursor, 4);

    do_move(2, 0);
    check("first.player", player, 1);

`ifdef MOVE_SEQ_CPU_EN
    cpu_req = 1; cpu_col = 3'd7;
    step();
    cpu_req = 0;
    check("cpu_bad.ack",  cpu_ack,     1);
    check("cpu_bad.drop", drop_active, 0);
    check_status("cpu_bad");
    step();
    check("cpu_bad.ack_once", cpu_ack, 0);
    do_move(4, 0);
    check("cpu_good.player", player, 0);
    do_move(5, 0);
`else
    cpu_req = 1; cpu_col = 3'd4;
    step();
    cpu_req = 0;
    check("cpu_off.ack",  cpu_ack,     0);
    check("cpu_off.drop", drop_active, 0);
    check_status("cpu_off");
`endif

    for (int i = 0; i < 6; i++) do_move(0, 0);
    check("fill.full0", col_full[0], 1);
    start_drop(0, started);
    check("fill.refused", started, 0);

    for (int k = 0; k < 7; k++) do_move((k % 2) ? 4 : 1, (k == 6) ? 1 : 0);
    check("red.win", win, 2'b01);
    pulse_move(1, 0);
    pulse_move(0, 1);
    check_done = 1; win_in = 2'b10; tick = 1;
    step();
    clear_inputs();
    check_status("over.hold");
    restart();
    check("restart.cursor", cursor, 3);

    for (int g = 0; g < 3; g++) begin
      for (int guard = 0; guard < 120 && m_win == 0; guard++) begin
        int c, code;
        if ($urandom_range(7) == 0) begin
          c = $urandom_range(6);
        end else begin
          c = $urandom_range(6);
          for (int s = 0; s < 7 && m_h[c] == 6; s++) c = (c + 1) % 7;
        end
        code = ($urandom_range(15) == 0) ? 1 + $urandom_range(1) : 0;
        do_move(c, code);
      end
      check("rand.over", (win != 2'b00), (m_win != 0));
      restart();
    end

    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) do_move(c, 0);
    check("draw.win",  win,      2'b11);
    check("draw.full", col_full, 7'h7f);
    restart();

    navigate(5);
    enter = 1;
    step();
    enter = 0;
    check("middrop.active", drop_active, 1);
    tick = 1;
    step();
    tick = 0;
    reset = 1;
    step();
    reset = 0;
    model_reset();
    check_status("middrop.reset");
    check("middrop.drop_row", drop_row, 0);
    do_move(5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
